// File: rtl/shiftadd_pkg.sv
// ---------------------------------------------------------------------------
// shiftadd_pkg
// Shared definitions for the parametrised shift-add multiplier.
//   state_t    : controller state encoding (2 bits)
//   cnt_width  : width of a down-counter able to hold the value 'width'
// ---------------------------------------------------------------------------
package shiftadd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_FINISH = 2'b10
    } state_t;

    // Bits needed to load the operand width itself into the bit counter.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shiftadd_datapath_param.sv
// ---------------------------------------------------------------------------
// shiftadd_datapath_param
// Accumulator, multiplicand register and adder/shifter of the shift-add
// multiplier. Operands are reduced to magnitudes on load; the sign of the
// result is reapplied when the product register is written on finish.
//
// Ports
//   i_clk           rising-edge clock
//   i_rst           asynchronous active-high reset
//   i_load          capture operands, mode and sign flag
//   i_step          one multiply iteration (conditional add, then shift)
//   i_add           add the multiplicand this step (driven from acc[0])
//   i_finish        write the signed-corrected product register
//   i_signed_mode   operands are two's complement when 1
//   i_multiplicand  operand A
//   i_multiplier    operand B
//   o_acc_lsb       accumulator bit 0 (current multiplier bit)
//   o_product       registered result, 2*WIDTH bits
// ---------------------------------------------------------------------------
module shiftadd_datapath_param
    import shiftadd_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic               i_step,
    input  logic               i_add,
    input  logic               i_finish,
    input  logic               i_signed_mode,
    input  logic [WIDTH-1:0]   i_multiplicand,
    input  logic [WIDTH-1:0]   i_multiplier,
    output logic               o_acc_lsb,
    output logic [2*WIDTH-1:0] o_product
);

    logic [2*WIDTH:0]   r_acc;
    logic [WIDTH-1:0]   r_mcand;
    logic               r_neg;
    logic [2*WIDTH-1:0] r_product;

    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_low;

    assign w_neg_a = i_signed_mode & i_multiplicand[WIDTH-1];
    assign w_neg_b = i_signed_mode & i_multiplier[WIDTH-1];

    // The most negative operand negates to itself, which read as unsigned
    // is exactly its magnitude, so WIDTH bits are always enough.
    assign w_mag_a = w_neg_a ? (-i_multiplicand) : i_multiplicand;
    assign w_mag_b = w_neg_b ? (-i_multiplier)   : i_multiplier;

    // The top accumulator bit is always zero at the start of a step (it was
    // zero-filled by the previous shift), so including it in the addend is
    // equivalent to a WIDTH-bit add with carry out.
    assign w_sum = r_acc[2*WIDTH:WIDTH] + {1'b0, r_mcand};

    assign w_low = r_acc[2*WIDTH-1:0];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc     <= '0;
            r_mcand   <= '0;
            r_neg     <= 1'b0;
            r_product <= '0;
        end else begin
            if (i_load) begin
                r_acc   <= {{(WIDTH+1){1'b0}}, w_mag_b};
                r_mcand <= w_mag_a;
                r_neg   <= w_neg_a ^ w_neg_b;
            end else if (i_step) begin
                if (i_add) begin
                    r_acc <= {1'b0, w_sum, r_acc[WIDTH-1:1]};
                end else begin
                    r_acc <= {1'b0, r_acc[2*WIDTH:1]};
                end
            end

            // Negating a zero magnitude yields zero, so no -0 case exists.
            if (i_finish) begin
                r_product <= r_neg ? (-w_low) : w_low;
            end
        end
    end

    assign o_acc_lsb = r_acc[0];
    assign o_product = r_product;

endmodule

// File: rtl/shiftadd_multiplier_param.sv
// ---------------------------------------------------------------------------
// shiftadd_multiplier_param
// Sequential shift-add multiplier with a start/busy/done handshake and an
// optional two's-complement mode. One multiplier bit is consumed per clock;
// a result appears WIDTH+1 clocks after the accepted start edge.
//
// Ports
//   i_clk           rising-edge clock
//   i_rst           asynchronous active-high reset (aborts, no done pulse)
//   i_start         request, sampled only in IDLE
//   i_signed_mode   1 = signed operands/product, 0 = unsigned
//   i_multiplicand  operand A, sampled with start
//   i_multiplier    operand B, sampled with start
//   o_busy          high while an operation is in progress
//   o_done          one-cycle pulse, product valid
//   o_product       result, held until the next completion
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | waiting for start; operands are captured on the start edge
// ST_RUN    | one add/shift per edge, counter runs WIDTH down to 1
// ST_FINISH | sign correction into product, done pulse, back to idle
// ---------------------------------------------------------------------------
module shiftadd_multiplier_param
    import shiftadd_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_signed_mode,
    input  logic [WIDTH-1:0]   i_multiplicand,
    input  logic [WIDTH-1:0]   i_multiplier,
    output logic               o_busy,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_product
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;

    logic             w_load;
    logic             w_step;
    logic             w_add;
    logic             w_finish;
    logic             w_acc_lsb;

    assign w_load   = (r_state == ST_IDLE) & i_start;
    assign w_step   = (r_state == ST_RUN);
    assign w_add    = w_step & w_acc_lsb;
    assign w_finish = (r_state == ST_FINISH);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_cnt   <= CNT_W'(WIDTH);
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    // Terminal count: this edge performs the last step.
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    shiftadd_datapath_param #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_load         (w_load),
        .i_step         (w_step),
        .i_add          (w_add),
        .i_finish       (w_finish),
        .i_signed_mode  (i_signed_mode),
        .i_multiplicand (i_multiplicand),
        .i_multiplier   (i_multiplier),
        .o_acc_lsb      (w_acc_lsb),
        .o_product      (o_product)
    );

    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule

// File: tb/tb_shiftadd_multiplier_param.sv
module tb_shiftadd_multiplier_param;

    localparam int WIDTH = 8;

    logic               clk;
    logic               rst;
    logic               start;
    logic               signed_mode;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;

    int n_checks = 0;
    int n_pass   = 0;
    logic [2*WIDTH-1:0] prev_product = '0;

    shiftadd_multiplier_param #(
        .WIDTH (WIDTH)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .i_signed_mode  (signed_mode),
        .i_multiplicand (mcand),
        .i_multiplier   (mplier),
        .o_busy         (busy),
        .o_done         (done),
        .o_product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge. Drives start with the operands, then scrambles the
    // operand inputs while running and optionally pulses start mid-run.
    // Returns at the negedge on which done is seen.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic sm, input logic [15:0] exp, input int glitch_at);
        int lat;
        start       = 1'b1;
        mcand       = a;
        mplier      = b;
        signed_mode = sm;
        @(posedge clk);
        @(negedge clk);
        start       = 1'b0;
        mcand       = ~a;
        mplier      = b ^ 8'h5A;
        signed_mode = ~sm;
        check_eq({tag, " busy"}, 32'(busy), 32'd1);
        check_eq({tag, " held"}, 32'(product), 32'(prev_product));
        lat = 0;
        while (!done && lat < 30) begin
            if (lat == glitch_at) begin
                start  = 1'b1;
                mcand  = 8'hFF;
                mplier = 8'hFF;
            end
            @(negedge clk);
            start = 1'b0;
            lat++;
        end
        check_eq({tag, " latency"}, 32'(lat), 32'(WIDTH + 1));
        check_eq({tag, " product"}, 32'(product), 32'(exp));
        check_eq({tag, " busy_at_done"}, 32'(busy), 32'd0);
        prev_product = exp;
    endtask

    initial begin
        int dones;
        rst         = 1'b1;
        start       = 1'b0;
        signed_mode = 1'b0;
        mcand       = '0;
        mplier      = '0;
        repeat (2) @(negedge clk);
        check_eq("reset busy", 32'(busy), 32'd0);
        check_eq("reset done", 32'(done), 32'd0);
        check_eq("reset product", 32'(product), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("u13x11",    8'd13,  8'd11,  1'b0, 16'h008F, -1);
        @(negedge clk);
        check_eq("u13x11 done width", 32'(done), 32'd0);
        check_eq("u13x11 product hold", 32'(product), 32'h008F);

        run_op("u255x255",  8'hFF,  8'hFF,  1'b0, 16'hFE01, -1);
        run_op("s-3x5",     8'hFD,  8'h05,  1'b1, 16'hFFF1, -1);
        run_op("u253x5",    8'hFD,  8'h05,  1'b0, 16'h04F1, -1);
        run_op("s-128x-128",8'h80,  8'h80,  1'b1, 16'h4000, -1);
        run_op("s-128x1",   8'h80,  8'h01,  1'b1, 16'hFF80, -1);
        run_op("s127x-128", 8'h7F,  8'h80,  1'b1, 16'hC080, -1);
        run_op("s-1x-1",    8'hFF,  8'hFF,  1'b1, 16'h0001, -1);
        run_op("s0x-5",     8'h00,  8'hFB,  1'b1, 16'h0000, -1);
        run_op("u200x0",    8'd200, 8'h00,  1'b0, 16'h0000, -1);
        @(negedge clk);

        // start with new operands mid-run must be ignored
        run_op("glitch",    8'd13,  8'd11,  1'b0, 16'h008F, 3);
        // start in the done cycle is accepted
        run_op("b2b",       8'd7,   8'd9,   1'b0, 16'h003F, -1);
        @(negedge clk);

        // asynchronous reset between edges in the middle of a run
        start       = 1'b1;
        mcand       = 8'd200;
        mplier      = 8'd100;
        signed_mode = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("async rst busy", 32'(busy), 32'd0);
        check_eq("async rst done", 32'(done), 32'd0);
        check_eq("async rst product", 32'(product), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        prev_product = '0;
        dones = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) dones++;
        end
        check_eq("no done after rst", 32'(dones), 32'd0);
        check_eq("idle after rst", 32'(busy), 32'd0);

        // random operands against an integer reference product
        for (int i = 0; i < 300; i++) begin
            logic [7:0]  ra, rb;
            logic        rs;
            int          sa, sb, full;
            logic [15:0] exp;
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rs   = 1'($urandom);
            sa   = rs ? int'($signed(ra)) : int'(ra);
            sb   = rs ? int'($signed(rb)) : int'(rb);
            full = sa * sb;
            exp  = full[15:0];
            run_op("rand", ra, rb, rs, exp, -1);
            @(negedge clk);
            check_eq("rand done width", 32'(done), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
